// File: rtl/gcm_ghash_tag_accum_pkg.sv
// Shared GCM definitions: GHASH input selects, GF(2^128) reduction constant
// and the tag-accumulator state encoding.
package gcm_ghash_tag_accum_pkg;

   localparam int unsigned SEL_DATA   = 0;
   localparam int unsigned SEL_LENGTH = 1;

   // SP 800-38D reduction polynomial: 0xE1 || 0^120 (MSB holds the x^0 coefficient)
   localparam logic [127:0] GCM_R = {8'hE1, 120'h0};

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACCUM    = 2'd1,
      ST_LEN_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/gcm_ghash_tag_accum_gf128_mult.sv
// Combinational 128x128 GF(2^128) multiply in GCM bit order (shift-and-xor).
module gf128_mult
   import gcm_ghash_tag_accum_pkg::*;
#(
   parameter int unsigned NB_BLOCK = 128
) (
   input  logic [NB_BLOCK-1:0] a,
   input  logic [NB_BLOCK-1:0] b,
   output logic [NB_BLOCK-1:0] p
);

   logic [NB_BLOCK-1:0] z;
   logic [NB_BLOCK-1:0] v;
   logic [NB_BLOCK-1:0] bb;

   // b is scanned from its MSB (x^0) downwards by shifting left, keeping every index constant
   always_comb begin
      z  = '0;
      v  = a;
      bb = b;
      for (int unsigned i = 0; i < NB_BLOCK; i++) begin
         if (bb[NB_BLOCK-1]) begin
            z = z ^ v;
         end
         if (v[0]) begin
            v = (v >> 1) ^ GCM_R;
         end else begin
            v = v >> 1;
         end
         bb = bb << 1;
      end
      p = z;
   end

endmodule

// File: rtl/gcm_ghash_tag_accum.sv
// GHASH accumulator and tag generator: Y <= (Y ^ X) * H per block, T = Y ^ E(K,J0).
module gcm_ghash_tag_accum
   import gcm_ghash_tag_accum_pkg::*;
#(
   parameter int unsigned NB_BLOCK = 128,
   parameter int unsigned NB_SEL   = 2
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_valid,
   input  logic                i_sop,
   input  logic [NB_SEL-1:0]   i_sel_ghash_in,
   input  logic                i_valid_ghash,
   input  logic                i_valid_tag,
   input  logic [NB_BLOCK-1:0] i_data_block,
   input  logic [NB_BLOCK-1:0] i_length_block,
   input  logic [NB_BLOCK-1:0] i_h_key,
   input  logic [NB_BLOCK-1:0] i_ekj0,
   input  logic                i_ekj0_valid,
   output logic [NB_BLOCK-1:0] o_ghash,
   output logic [NB_BLOCK-1:0] o_tag,
   output logic                o_tag_valid,
   output logic                o_error
);

   state_t              state;
   state_t              state_nxt;
   logic                sel_len;
   logic                do_accum;
   logic                do_tag;
   logic                err_evt;
   logic [NB_BLOCK-1:0] y;
   logic [NB_BLOCK-1:0] y_src;
   logic [NB_BLOCK-1:0] x_blk;
   logic [NB_BLOCK-1:0] mult_out;
   logic [NB_BLOCK-1:0] ekj0_reg;
   logic [NB_BLOCK-1:0] tag;
   logic                tag_valid;
   logic                error;

   assign sel_len = (i_sel_ghash_in == NB_SEL'(SEL_LENGTH));

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state <= ST_IDLE;
      end else if (i_valid) begin
         state <= state_nxt;
      end
   end

   // sop overrides everything; a tag strobe coinciding with sop still closes the old frame
   always_comb begin
      state_nxt = state;
      if (i_sop) begin
         state_nxt = ST_ACCUM;
      end
      if (do_accum && sel_len) begin
         state_nxt = ST_LEN_DONE;
      end else if (do_tag && !i_sop) begin
         state_nxt = ST_IDLE;
      end
   end

   always_comb begin
      do_accum = i_valid_ghash && (i_sop || (state == ST_ACCUM));
      do_tag   = i_valid_tag && (state == ST_LEN_DONE);
      err_evt  = (i_valid_ghash && !i_sop && (state != ST_ACCUM)) ||
                 (i_valid_tag && (state != ST_LEN_DONE));
   end

   assign y_src = i_sop ? '0 : y;
   assign x_blk = sel_len ? i_length_block : i_data_block;

   gf128_mult #(
      .NB_BLOCK (NB_BLOCK)
   ) u_mult (
      .a (y_src ^ x_blk),
      .b (i_h_key),
      .p (mult_out)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         y         <= '0;
         ekj0_reg  <= '0;
         tag       <= '0;
         tag_valid <= 1'b0;
         error     <= 1'b0;
      end else if (i_valid) begin
         if (do_accum) begin
            y <= mult_out;
         end else if (i_sop) begin
            y <= '0;
         end
         if (i_ekj0_valid) begin
            ekj0_reg <= i_ekj0;
         end
         tag_valid <= do_tag;
         if (do_tag) begin
            tag <= y ^ ekj0_reg;
         end
         if (err_evt) begin
            error <= 1'b1;
         end
      end
   end

   assign o_ghash     = y;
   assign o_tag       = tag;
   assign o_tag_valid = tag_valid;
   assign o_error     = error;

endmodule

// File: doc/gcm_ghash_tag_accum.md
# gcm_ghash_tag_accum

Downstream consumer of the GCM tag sequencer's valid/select strobes. It runs the GHASH recurrence Y <= (Y ^ X) · H over GF(2^128), one block per enabled cycle. X is the ciphertext block, or the len(A)||len(C) block when the sequencer selects length. On the sequencer's tag strobe it produces the authentication tag T = Y ^ E(K,J0). It sits between the AES-CTR datapath / tag sequencer and the frame output stage.

## Interface
Parameters:
- NB_BLOCK, 128, block / field-element width (only 128 is supported).
- NB_SEL, 2, width of the GHASH input select.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  global clock-enable; every register updates only when high.
- i_sop  in  1  start of frame; clears the accumulator.
- i_sel_ghash_in  in  NB_SEL  0 = data block, 1 = length block, others reserved (treated as data).
- i_valid_ghash  in  1  the selected block is accumulated this cycle.
- i_valid_tag  in  1  finalise the tag this cycle.
- i_data_block  in  NB_BLOCK  ciphertext block.
- i_length_block  in  NB_BLOCK  64-bit len(A) concatenated with 64-bit len(C), in bits.
- i_h_key  in  NB_BLOCK  hash subkey H, held stable per frame.
- i_ekj0  in  NB_BLOCK  E(K,J0).
- i_ekj0_valid  in  1  load i_ekj0.
- o_ghash  out  NB_BLOCK  current accumulator Y.
- o_tag  out  NB_BLOCK  authentication tag.
- o_tag_valid  out  1  o_tag is valid.
- o_error  out  1  sticky protocol error.

## Operation
Bit order follows SP 800-38D:
- bit NB_BLOCK-1 holds the x^0 coefficient.
- Reduction uses R = 0xE1 followed by 120 zeros.

FSM states are IDLE, ACCUM, LEN_DONE. Every transition is qualified by i_valid.
- IDLE -> ACCUM on i_sop.
- ACCUM -> LEN_DONE when i_valid_ghash is high with length selected.
- LEN_DONE -> IDLE when i_valid_tag is high.
- i_sop in any state clears Y and enters ACCUM. A frame aborted mid-operation is discarded with no tag.

Accumulate:
- When i_valid & i_valid_ghash: Y <= (Ysrc ^ X) · H.
- Ysrc is 0 if i_sop is high in the same cycle, otherwise Y.

E(K,J0):
- i_ekj0_valid & i_valid loads the ekj0 register.
- If this coincides with i_valid_tag, the tag uses the old register value.

Tag:
- When i_valid & i_valid_tag in LEN_DONE: o_tag <= Y ^ ekj0_reg and o_tag_valid <= 1.
- On any other enabled cycle, o_tag_valid <= 0.
- o_tag holds its value until the next tag.

Errors (o_error is sticky until reset; the offending event is ignored):
- i_valid_ghash while in IDLE or LEN_DONE, without i_sop.
- i_valid_tag outside LEN_DONE.

## Timing
- Reset values: Y, o_ghash, o_tag and ekj0_reg = 0; o_tag_valid = 0; o_error = 0; state = IDLE.
- Accumulate latency: 1 enabled cycle. A block presented at cycle t is reflected in o_ghash at t+1.
- Throughput: one block per enabled cycle; no back-pressure.
- Tag latency: 1 enabled cycle from i_valid_tag. With the sequencer's strobes, length at t, tag strobe at t+2, o_tag_valid at t+3.
- i_valid low freezes everything, including o_tag_valid. Consumers qualify o_tag_valid with i_valid.
- Reset mid-frame: the next cycle shows the reset values; no tag is emitted.
- The multiply is single-cycle combinational; its timing closure is owned by the sub-module.

## Structure
Shared gcm package holds:
- SEL_DATA = 0 and SEL_LENGTH = 1, shared with the tag sequencer.
- the reduction constant R.
- the state encodings.

Sub-module gf128_mult: purely combinational 128x128 GCM multiply (shift-and-xor over 128 bits with R reduction). It is reused by later GHASH variants. The top level holds the FSM, the registers and the muxing.

## Test plan
- Reset, then idle -> all outputs 0; o_tag_valid never asserts.
- Empty frame, NIST test case 1:
  - H = 66e94bd4ef8a2c3b884cfa59ca342b2e, EkJ0 = 58e2fccefa7e3061367f1d57a4e7455a, length block all zero.
  - Expected: o_ghash = 0, o_tag = 58e2fccefa7e3061367f1d57a4e7455a.
- One-block frame, NIST test case 2:
  - Data 0388dace60b6a392f328c2b971b2fe78, length block 000..080, same H and EkJ0.
  - Expected: o_tag = ab6e47d42cec13bdf53a67b21257bddf, with o_tag_valid one enabled cycle after i_valid_tag.
- Test case 2 with i_valid toggling 0/1 every cycle -> same tag; o_tag_valid is held across the disabled cycles.
- i_sop asserted mid-frame, then test case 2 replayed -> the correct tag is produced; the aborted frame produces no tag.
- i_valid_tag without a preceding length block -> o_error = 1 and held; o_tag unchanged; o_tag_valid stays 0.
